// File: rtl/wb_port_arb.sv
// wb_port_arb: shares the register-file write port between the WB stage and a 2-entry MDU result buffer
module wb_port_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_aluOut_WB_memOut,
    input  logic        wb_writeReg,
    input  logic [31:0] wb_outMem,
    input  logic [31:0] wb_outAlu,
    input  logic [4:0]  wb_rd,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic [1:0]  buf_count
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [1:0] bufCount, state, stateNext;
    logic [3:0] starveCnt, starveNext;
    logic [4:0] bufRd [2];
    logic [31:0] bufData [2];
    logic pipeWe, accept, pop, bypass, push, tailHi;

    assign pipeWe = wb_writeReg && wb_rd != 5'd0;
    assign mdu_ready = bufCount != 2'd2;
    assign accept = mdu_valid && mdu_ready;
    assign pop = !pipeWe && bufCount != 2'd0;
    assign bypass = !pipeWe && bufCount == 2'd0 && accept && mdu_rd != 5'd0;
    assign push = accept && mdu_rd != 5'd0 && !bypass;
    assign tailHi = bufCount == 2'd1 && !pop;
    assign rf_we = pipeWe || pop || bypass;
    assign rf_waddr = pipeWe ? wb_rd : pop ? bufRd[0] : mdu_rd;
    assign rf_wdata = pipeWe ? (wb_aluOut_WB_memOut ? wb_outMem : wb_outAlu) : pop ? bufData[0] : mdu_data;
    assign stall_req = state == REQ;
    assign buf_count = bufCount;

    // REQ is entered on the edge where the counter reaches the limit, bounding the head wait to LIMIT+2
    always_comb begin
        starveNext = (pop || bufCount == 2'd0) ? 4'd0 : (pipeWe && starveCnt != LIMIT) ? starveCnt + 4'd1 : starveCnt;
        stateNext = state == IDLE ? (starveNext == LIMIT ? REQ : IDLE) :
                    state == REQ ? DRAIN :
                    state == DRAIN ? (pipeWe ? REQ : IDLE) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufCount <= 2'd0;
            starveCnt <= 4'd0;
            state <= IDLE;
        end else begin
            bufCount <= bufCount - {1'b0, pop} + {1'b0, push};
            starveCnt <= starveNext;
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            bufRd[0] <= bufRd[1];
            bufData[0] <= bufData[1];
        end
        if (push) begin
            bufRd[tailHi] <= mdu_rd;
            bufData[tailHi] <= mdu_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: directed checks of write-port priority, buffering, starvation bubbles and async reset
module tb_wb_port_arb;
    logic clk = 1'b0, rst = 1'b1;
    logic sel = 1'b0, wbWe = 1'b0, mduValid = 1'b0;
    logic [31:0] outMem = '0, outAlu = '0, mduData = '0;
    logic [4:0] wbRd = '0, mduRd = '0;
    logic mduReady, rfWe, stallReq;
    logic [4:0] rfWaddr;
    logic [31:0] rfWdata;
    logic [1:0] bufCount;
    int total = 0, bad = 0;

    wb_port_arb #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .wb_aluOut_WB_memOut(sel), .wb_writeReg(wbWe),
        .wb_outMem(outMem), .wb_outAlu(outAlu), .wb_rd(wbRd),
        .mdu_valid(mduValid), .mdu_rd(mduRd), .mdu_data(mduData), .mdu_ready(mduReady),
        .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
        .stall_req(stallReq), .buf_count(bufCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [4:0] rd);
        wbWe = we;
        wbRd = rd;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mduValid = v;
        mduRd = rd;
        mduData = d;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("rst_count", 32'(bufCount), 0);
        chk("rst_ready", 32'(mduReady), 1);
        chk("rst_stall", 32'(stallReq), 0);
        chk("rst_we", 32'(rfWe), 0);
        rst = 1'b0;

        @(negedge clk);
        wb(1, 5); sel = 1'b1; outMem = 32'hDEADBEEF; outAlu = 32'h1; #1;
        chk("pipe_we", 32'(rfWe), 1);
        chk("pipe_addr", 32'(rfWaddr), 5);
        chk("pipe_mem", rfWdata, 32'hDEADBEEF);
        sel = 1'b0; #1;
        chk("pipe_alu", rfWdata, 32'h1);
        wbRd = 5'd0; #1;
        chk("pipe_x0", 32'(rfWe), 0);

        @(negedge clk);
        wb(0, 0); mdu(1, 7, 32'h1234); #1;
        chk("byp_we", 32'(rfWe), 1);
        chk("byp_addr", 32'(rfWaddr), 7);
        chk("byp_data", rfWdata, 32'h1234);
        @(negedge clk);
        mdu(1, 0, 32'h5); #1;
        chk("byp_count", 32'(bufCount), 0);
        chk("drop_we", 32'(rfWe), 0);
        @(negedge clk);
        mdu(0, 0, 0); #1;
        chk("drop_count", 32'(bufCount), 0);

        @(negedge clk);
        wb(1, 10); sel = 1'b0; outAlu = 32'hAAAA; mdu(1, 3, 32'h33); #1;
        chk("buf_pipe_wins", 32'(rfWaddr), 10);
        @(negedge clk);
        mdu(1, 4, 32'h44); #1;
        chk("buf_count1", 32'(bufCount), 1);
        chk("buf_ready1", 32'(mduReady), 1);
        @(negedge clk);
        mdu(1, 5, 32'h55); #1;
        chk("buf_count2", 32'(bufCount), 2);
        chk("buf_full", 32'(mduReady), 0);
        @(negedge clk); #1;
        chk("buf_held", 32'(bufCount), 2);
        wb(0, 0); #1;
        chk("drain3_we", 32'(rfWe), 1);
        chk("drain3_addr", 32'(rfWaddr), 3);
        chk("drain3_data", rfWdata, 32'h33);
        chk("drain3_ready", 32'(mduReady), 0);
        @(negedge clk); #1;
        chk("drain4_addr", 32'(rfWaddr), 4);
        chk("drain4_data", rfWdata, 32'h44);
        chk("drain4_ready", 32'(mduReady), 1);
        @(negedge clk);
        mdu(0, 0, 0); #1;
        chk("drain5_count", 32'(bufCount), 1);
        chk("drain5_addr", 32'(rfWaddr), 5);
        chk("drain5_data", rfWdata, 32'h55);
        @(negedge clk); #1;
        chk("drained_count", 32'(bufCount), 0);
        chk("drained_we", 32'(rfWe), 0);

        @(negedge clk);
        wb(1, 10); mdu(1, 9, 32'h99);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mdu(0, 0, 0); #1;
            chk($sformatf("starve_wait%0d", i), 32'(stallReq), 0);
        end
        @(negedge clk); #1;
        chk("starve_req", 32'(stallReq), 1);
        chk("starve_req_pipe", 32'(rfWaddr), 10);
        @(negedge clk);
        wb(0, 0); #1;
        chk("starve_drain_stall", 32'(stallReq), 0);
        chk("starve_drain_addr", 32'(rfWaddr), 9);
        chk("starve_drain_data", rfWdata, 32'h99);
        @(negedge clk); #1;
        chk("starve_idle_stall", 32'(stallReq), 0);
        chk("starve_idle_count", 32'(bufCount), 0);

        @(negedge clk);
        wb(1, 10); mdu(1, 12, 32'hCC);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mdu(0, 0, 0);
        end
        @(negedge clk); #1;
        chk("viol_req", 32'(stallReq), 1);
        @(negedge clk); #1;
        chk("viol_drain_stall", 32'(stallReq), 0);
        chk("viol_pipe_addr", 32'(rfWaddr), 10);
        chk("viol_count", 32'(bufCount), 1);
        @(negedge clk); #1;
        chk("viol_rereq", 32'(stallReq), 1);
        @(negedge clk);
        wb(0, 0); #1;
        chk("viol_drain_addr", 32'(rfWaddr), 12);
        chk("viol_drain_data", rfWdata, 32'hCC);
        @(negedge clk); #1;
        chk("viol_idle_count", 32'(bufCount), 0);
        chk("viol_idle_stall", 32'(stallReq), 0);

        @(negedge clk);
        wb(1, 10); mdu(1, 13, 32'hD13);
        @(negedge clk);
        mdu(1, 14, 32'hD14);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mdu(0, 0, 0);
        end
        @(negedge clk); #1;
        chk("ar_pre_stall", 32'(stallReq), 1);
        chk("ar_pre_count", 32'(bufCount), 2);
        #1 rst = 1'b1; #1;
        chk("ar_count", 32'(bufCount), 0);
        chk("ar_stall", 32'(stallReq), 0);
        chk("ar_ready", 32'(mduReady), 1);
        @(negedge clk);
        wb(0, 0); rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("ar_nowrite%0d", i), 32'(rfWe), 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
